// File: rtl/fpadd_sched.sv
// fpadd_sched: round-robin scheduler sharing one FP32 adder among NREQ requesters,
// with a tag pipeline returning results by ID and a hold/drain quiesce FSM.
module fpadd_sched #(
  parameter int NREQ = 4,
  parameter int LAT = 2,
  localparam int IDW = $clog2(NREQ),
  localparam int CW = $clog2(LAT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          fpa_a,
  output logic [31:0]          fpa_b,
  input  logic [31:0]          fpa_out,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  input  logic                 hold,
  output logic                 paused,
  output logic [CW-1:0]        inflight
);
  localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, PAUSED = 2'd2;
  logic [1:0] state, state_n;
  logic [IDW-1:0] ptr, gnt, j;
  logic found, xfer;
  logic [LAT-1:0] tv;
  logic [IDW-1:0] tid [LAT];
  always_comb begin
    gnt = ptr;
    found = 1'b0;
    j = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[j]) begin
        found = 1'b1;
        gnt = j;
      end
    end
  end
  assign xfer = (state == RUN) && !hold && !reset && found;
  assign req_ready = xfer ? NREQ'(1) << gnt : '0;
  // idle operands are zero so the adder's zero path yields 0
  assign fpa_a = xfer ? req_a[32*gnt +: 32] : '0;
  assign fpa_b = xfer ? req_b[32*gnt +: 32] : '0;
  assign rsp_valid = tv[LAT-1];
  assign rsp_id = tid[LAT-1];
  assign rsp_data = fpa_out;
  assign paused = state == PAUSED;
  always_comb begin
    inflight = '0;
    for (int k = 0; k < LAT; k++) inflight = inflight + CW'(tv[k]);
  end
  always_comb
    state_n = (state == RUN) ? (hold ? DRAIN : RUN) :
              !hold ? RUN :
              (state == DRAIN && inflight == '0) ? PAUSED : state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      ptr <= '0;
      tv <= '0;
      for (int k = 0; k < LAT; k++) tid[k] <= '0;
    end else begin
      state <= state_n;
      if (xfer) ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
      tv[0] <= xfer;
      tid[0] <= xfer ? gnt : '0;
      for (int k = 1; k < LAT; k++) begin
        tv[k] <= tv[k-1];
        tid[k] <= tid[k-1];
      end
    end
  end
endmodule

// File: tb/tb_fpadd_sched.sv
// tb_fpadd_sched: scenario tasks drive the scheduler against a behavioural FP32 adder;
// grants are checked inline and results via an expected-response queue.
module tb_fpadd_sched;
  logic clk = 1'b0, reset = 1'b0, hold = 1'b0;
  logic [3:0] req_valid = '0, req_ready;
  logic [127:0] req_a = '0, req_b = '0;
  logic [31:0] fpa_a, fpa_b, fpa_out, rsp_data;
  logic rsp_valid, paused;
  logic [1:0] rsp_id, inflight;
  logic [31:0] ar = '0, br = '0;
  logic [31:0] op_a [4], op_b [4], op_s [4];
  logic [33:0] sb [$];
  int passed = 0, total = 0;

  fpadd_sched #(.NREQ(4), .LAT(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_out(fpa_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .hold(hold), .paused(paused), .inflight(inflight)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'd0) return 0.0;
    e = 11'(x[30:23]) - 11'd127 + 11'd1023;
    return $bitstoreal({x[31], e, x[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'b0};
    return {d[63], 8'(d[62:52] - 11'd1023 + 11'd127), d[51:29]};
  endfunction

  // adder model: registered inputs, registered sum
  always @(posedge clk) begin
    ar <= fpa_a;
    br <= fpa_b;
    fpa_out <= r2f(f2r(ar) + f2r(br));
  end

  always @(negedge clk) begin
    if (rsp_valid) begin
      total++;
      if (sb.size() == 0) $display("FAIL rsp_unexpected got id=%0d data=%h want none", rsp_id, rsp_data);
      else begin
        logic [33:0] e;
        e = sb.pop_front();
        if ({rsp_id, rsp_data} !== e) $display("FAIL rsp got id=%0d data=%h want id=%0d data=%h", rsp_id, rsp_data, e[33:32], e[31:0]);
        else passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = op_a[i];
      req_b[32*i +: 32] = op_b[i];
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 4'b1111;
    load_ops();
    tick();
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", req_ready); else passed++;
    total++; if (fpa_a !== 32'h0) $display("FAIL reset_fpa_a got %h want 0", fpa_a); else passed++;
    total++; if ({rsp_valid, rsp_id, paused, inflight} !== 6'b0) $display("FAIL reset_outs got v=%b id=%0d p=%b inf=%0d want 0", rsp_valid, rsp_id, paused, inflight); else passed++;
    tick();
    reset = 1'b0;
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", req_ready); else passed++;
    total++; if ({fpa_a, fpa_b} !== {32'h3F800000, 32'h40000000}) $display("FAIL single_ops got %h %h want 3f800000 40000000", fpa_a, fpa_b); else passed++;
    sb.push_back({2'd0, 32'h40400000});
    tick();
    req_valid = '0;
    @(negedge clk);
    total++; if ({rsp_valid, inflight} !== 3'b0_01) $display("FAIL single_t1 got v=%b inf=%0d want v=0 inf=1", rsp_valid, inflight); else passed++;
    tick();
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1) $display("FAIL single_latency got v=%b want 1", rsp_valid); else passed++;
    tick();
    tick();
  endtask

  task automatic test_contention();
    pulse_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] e;
      e = 4'b0001 << (k % 4);
      @(negedge clk);
      total++; if (req_ready !== e) $display("FAIL contention_grant%0d got %b want %b", k, req_ready, e); else passed++;
      sb.push_back({2'(k % 4), op_s[k % 4]});
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_wrap();
    logic [3:0] e [3] = '{4'b1000, 4'b0001, 4'b1000};
    req_valid = 4'b0100;
    @(negedge clk);
    total++; if (req_ready !== 4'b0100) $display("FAIL wrap_pre got %b want 0100", req_ready); else passed++;
    sb.push_back({2'd2, op_s[2]});
    tick();
    req_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (req_ready !== e[k]) $display("FAIL wrap_grant%0d got %b want %b", k, req_ready, e[k]); else passed++;
      sb.push_back({(k == 1) ? 2'd0 : 2'd3, op_s[(k == 1) ? 0 : 3]});
      tick();
    end
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (req_ready !== 4'b0010) $display("FAIL single_repeat%0d got %b want 0010", k, req_ready); else passed++;
      sb.push_back({2'd1, op_s[1]});
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_hold();
    logic [1:0] ei [4] = '{2'd2, 2'd1, 2'd0, 2'd0};
    logic ep [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    pulse_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sb.push_back({2'(k), op_s[k]});
      tick();
    end
    hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if ({req_ready, inflight, paused} !== {4'b0, ei[k], ep[k]}) $display("FAIL hold_c%0d got rdy=%b inf=%0d p=%b want rdy=0000 inf=%0d p=%b", k, req_ready, inflight, paused, ei[k], ep[k]); else passed++;
      tick();
    end
    hold = 1'b0;
    @(negedge clk);
    total++; if ({req_ready, paused} !== 5'b0000_1) $display("FAIL hold_release got rdy=%b p=%b want 0000 1", req_ready, paused); else passed++;
    tick();
    @(negedge clk);
    total++; if ({req_ready, paused} !== 5'b0001_0) $display("FAIL hold_resume got rdy=%b p=%b want 0001 0", req_ready, paused); else passed++;
    sb.push_back({2'd0, op_s[0]});
    tick();
    req_valid = '0;
    repeat (3) tick();
    hold = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if ({req_ready, paused} !== {4'b0, k == 2}) $display("FAIL idle_hold_c%0d got rdy=%b p=%b want 0000 %0d", k, req_ready, paused, k == 2); else passed++;
      tick();
    end
    hold = 1'b0;
    tick();
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) $display("FAIL idle_hold_resume got %b want 0010", req_ready); else passed++;
    sb.push_back({2'd1, op_s[1]});
    tick();
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0010;
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) $display("FAIL rmid_issue got %b want 0010", req_ready); else passed++;
    tick();
    reset = 1'b1;
    req_valid = 4'b1111;
    sb.delete();
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) $display("FAIL rmid_ready got %b want 0000", req_ready); else passed++;
    tick();
    reset = 1'b0;
    req_valid = '0;
    @(negedge clk);
    total++; if ({rsp_valid, inflight} !== 3'b0) $display("FAIL rmid_flush got v=%b inf=%0d want 0 0", rsp_valid, inflight); else passed++;
    tick();
    req_valid = 4'b1111;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) $display("FAIL rmid_ptr got %b want 0001", req_ready); else passed++;
    sb.push_back({2'd0, op_s[0]});
    tick();
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_cancel();
    req_a[127:96] = 32'h40400000;
    req_b[127:96] = 32'hC0400000;
    req_valid = 4'b1000;
    @(negedge clk);
    total++; if (req_ready !== 4'b1000) $display("FAIL cancel_grant got %b want 1000", req_ready); else passed++;
    sb.push_back({2'd3, 32'h0});
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    total++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h0}) $display("FAIL cancel_rsp got v=%b data=%h want 1 00000000", rsp_valid, rsp_data); else passed++;
    repeat (3) tick();
  endtask

  initial begin
    op_a = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h40800000};
    op_b = '{32'h40000000, 32'h40000000, 32'h3F000000, 32'h40800000};
    op_s = '{32'h40400000, 32'h40800000, 32'h40000000, 32'h41000000};
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_hold();
    test_reset_mid();
    test_cancel();
    total++; if (sb.size() != 0) $display("FAIL sb_drained got %0d pending want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
